// File: rtl/btn_pkg.sv
// Shared types and helpers for the button front end and system-reset controller.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_RUN     = 2'd1,
    ST_BTN_RST = 2'd2,
    ST_HOLD    = 2'd3
  } rst_state_t;

  // Ceiling log2 with a floor of 1 so every counter has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_reset_ctrl_if.sv
// Board-side button levels and the clean levels, events and reset derived from them.
interface btn_reset_ctrl_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_state;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             sys_rst;
  logic             rst_busy;

  modport master (
    input  btn_in,
    output btn_state, btn_press, btn_release, sys_rst, rst_busy
  );

  modport slave (
    output btn_in,
    input  btn_state, btn_press, btn_release, sys_rst, rst_busy
  );
endinterface

// File: rtl/btn_debounce.sv
// One button channel: synchroniser, persistence counter, clean level and edge pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Any return to the accepted level restarts the persistence count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      press  <= 1'b0;
      rel    <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level <= ~level;
        cnt_q <= '0;
        press <= ~level;
        rel   <= level;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_reset_ctrl.sv
// Debounced button front end plus power-on / reset-button system reset sequencer.
module btn_reset_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned RST_BTN      = 0,
  parameter int unsigned RST_HOLD     = 16
) (
  input logic             clk,
  input logic             rst_n,
  btn_reset_ctrl_if.master bus
);

  localparam int unsigned HW = clog2(RST_HOLD + 1);

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] rel_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.btn_in[i]),
      .level(level_v[i]),
      .press(press_v[i]),
      .rel  (rel_v[i])
    );
  end

  assign bus.btn_state   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;

  rst_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q;
  logic          rst_lvl;
  logic          hold_done;

  assign rst_lvl   = level_v[RST_BTN];
  assign hold_done = (hold_q == HW'(RST_HOLD - 1));

  // sys_rst and rst_busy share one flop: reset is asserted exactly when not in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_POR;
      hold_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d != ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      ST_POR: begin
        if (hold_done) state_d = ST_RUN;
        else           hold_d  = hold_q + HW'(1);
      end
      ST_RUN: begin
        if (rst_lvl) state_d = ST_BTN_RST;
      end
      ST_BTN_RST: begin
        if (!rst_lvl) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (rst_lvl)        state_d = ST_BTN_RST;
        else if (hold_done) state_d = ST_RUN;
        else                hold_d  = hold_q + HW'(1);
      end
      default: state_d = ST_POR;
    endcase
  end

  assign bus.sys_rst  = busy_q;
  assign bus.rst_busy = busy_q;

endmodule
